// File: rtl/qpsk_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : qpsk_tx_ctrl
//  Description : Frame sequencer ahead of the QPSK modulator. Accepts payload
//                bytes on a valid/ready stream, frames them as preamble /
//                payload / guard, and emits paced 2-bit {I,Q} symbols, each
//                held for SPS clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module qpsk_tx_ctrl #(
    parameter int SPS           = 4,
    parameter int PREAMBLE_SYMS = 8,
    parameter int GUARD_SYMS    = 2,
    parameter int LEN_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [7:0]       i_data,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    input  logic             i_mod_ready,
    output logic             o_sym_I,
    output logic             o_sym_Q,
    output logic             o_sym_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_underrun
);

    localparam int CNT_W = LEN_W + 2;
    localparam int PH_W  = $clog2(SPS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRE   = 2'd1;
    localparam logic [1:0] S_PAY   = 2'd2;
    localparam logic [1:0] S_GUARD = 2'd3;

    localparam logic [PH_W-1:0]  c_PH_LAST  = PH_W'(SPS - 1);
    localparam logic [CNT_W-1:0] c_PRE_LAST = CNT_W'(PREAMBLE_SYMS - 1);
    localparam logic [CNT_W-1:0] c_GRD_LAST = CNT_W'(GUARD_SYMS - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [PH_W-1:0]  r_phase;
    logic [CNT_W-1:0] r_sym_cnt;      // symbols emitted in the current state
    logic [CNT_W-1:0] r_fetched;      // payload bytes accepted this frame
    logic [LEN_W-1:0] r_len;
    logic [7:0]       r_buf;
    logic             r_buf_valid;
    logic [7:0]       r_shift;        // remaining pairs of the byte on air
    logic [1:0]       r_sym;
    logic             r_sym_valid;
    logic             r_done;
    logic             r_underrun;

    logic             w_bnd;
    logic             w_need;
    logic             w_take;
    logic             w_under;
    logic             w_accept;
    logic [CNT_W-1:0] w_pay_last;

    // Symbol boundary: last phase of a symbol with the modulator accepting
    assign w_bnd      = (r_state != S_IDLE) && (r_phase == c_PH_LAST) && i_mod_ready;
    assign w_pay_last = {r_len, 2'b00} - CNT_W'(1);
    // A new byte is needed for the first payload symbol and after every 4th
    assign w_need     = w_bnd &&
                        (((r_state == S_PRE) && (r_sym_cnt == c_PRE_LAST) && (r_len != '0)) ||
                         ((r_state == S_PAY) && (r_sym_cnt[1:0] == 2'b11) && (r_sym_cnt != w_pay_last)));
    assign w_take     = w_need && r_buf_valid;
    assign w_under    = w_need && !r_buf_valid;
    assign w_accept   = i_data_valid && o_data_ready;

    assign o_sym_I     = r_sym[1];
    assign o_sym_Q     = r_sym[0];
    assign o_sym_valid = r_sym_valid;
    assign o_done      = r_done;
    assign o_underrun  = r_underrun;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; an underrun diverts straight into the guard
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_PRE;
            S_PRE:   if (w_bnd && (r_sym_cnt == c_PRE_LAST)) w_next = w_take ? S_PAY : S_GUARD;
            S_PAY:   if (w_bnd && ((r_sym_cnt == w_pay_last) || w_under)) w_next = S_GUARD;
            S_GUARD: if (w_bnd && (r_sym_cnt == c_GRD_LAST)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs; ready also opens when the buffer drains this cycle
    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_data_ready = ((r_state == S_PRE) || (r_state == S_PAY)) &&
                       (!r_buf_valid || w_take) &&
                       (r_fetched < {2'b00, r_len});
    end

    // Pacing counters, byte path and symbol register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= '0;
            r_sym_cnt   <= '0;
            r_fetched   <= '0;
            r_len       <= '0;
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_shift     <= '0;
            r_sym       <= 2'b00;
            r_sym_valid <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done     <= w_bnd && (r_state == S_GUARD) && (r_sym_cnt == c_GRD_LAST);
            r_underrun <= w_under;

            if (r_state == S_IDLE) begin
                r_phase     <= '0;
                r_sym_cnt   <= '0;
                r_fetched   <= '0;
                r_sym       <= 2'b00;
                r_sym_valid <= i_start;
                if (i_start) r_len <= i_len;
            end else begin
                if (i_mod_ready) r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + PH_W'(1);
                if (w_accept)    r_fetched <= r_fetched + CNT_W'(1);
                r_sym_valid <= w_bnd && (w_next != S_IDLE);
                if (w_bnd) begin
                    r_sym_cnt <= (w_next != r_state) ? '0 : r_sym_cnt + CNT_W'(1);
                    case (w_next)
                        S_PRE:   r_sym <= r_sym_cnt[0] ? 2'b00 : 2'b11;
                        S_PAY:   r_sym <= w_take ? r_buf[7:6] : r_shift[7:6];
                        default: r_sym <= 2'b00;
                    endcase
                end
            end

            // Shift register: reload from the buffer, else step one pair
            if (w_take)                           r_shift <= {r_buf[5:0], 2'b00};
            else if (w_bnd && (r_state == S_PAY)) r_shift <= {r_shift[5:0], 2'b00};

            // Holding buffer; leftovers are discarded outside the data states
            if ((r_state == S_IDLE) || (r_state == S_GUARD)) begin
                r_buf_valid <= 1'b0;
            end else if (w_accept) begin
                r_buf       <= i_data;
                r_buf_valid <= 1'b1;
            end else if (w_take) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qpsk_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qpsk_tx_ctrl
//  Description : Directed self-checking bench for qpsk_tx_ctrl
//                (SPS=4, PREAMBLE_SYMS=8, GUARD_SYMS=2, LEN_W=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qpsk_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_len = 8'd0;
    logic [7:0] i_data = 8'd0;
    logic       i_data_valid = 1'b0;
    logic       o_data_ready;
    logic       i_mod_ready = 1'b1;
    logic       o_sym_I, o_sym_Q, o_sym_valid, o_busy, o_done, o_underrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Monitor state
    logic [1:0] sym_q[$];
    int         sym_t[$];
    int         done_cnt, done_t, und_cnt, und_t;
    bit         busy_at_done, ready_seen;

    qpsk_tx_ctrl #(.SPS(4), .PREAMBLE_SYMS(8), .GUARD_SYMS(2), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .i_mod_ready(i_mod_ready), .o_sym_I(o_sym_I), .o_sym_Q(o_sym_Q),
        .o_sym_valid(o_sym_valid), .o_busy(o_busy), .o_done(o_done),
        .o_underrun(o_underrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record symbol starts and pulses on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_sym_valid) begin
                sym_q.push_back({o_sym_I, o_sym_Q});
                sym_t.push_back(cyc);
            end
            if (o_done) begin
                done_cnt++;
                done_t = cyc;
                busy_at_done = o_busy;
            end
            if (o_underrun) begin
                und_cnt++;
                und_t = cyc;
            end
            if (o_data_ready) ready_seen = 1'b1;
        end
    end

    task automatic clear_mon();
        sym_q.delete();
        sym_t.delete();
        done_cnt = 0; done_t = 0; und_cnt = 0; und_t = 0;
        busy_at_done = 1'b1; ready_seen = 1'b0;
    endtask

    // Start a frame and optionally hand over one payload byte
    task automatic start_frame(input logic [7:0] len, input bit with_byte, input logic [7:0] b);
        clear_mon();
        i_len = len; i_start = 1'b1; i_data = b; i_data_valid = with_byte;
        @(posedge clk); #1;
        i_start = 1'b0;
        if (with_byte) begin
            for (int k = 0; k < 20; k++) begin
                if (o_data_ready) break;
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            i_data_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin to = 1'b0; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_syms(input int n, output bit to);
        to = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (sym_q.size() >= n) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            i_start = k[0]; i_data_valid = ~k[0]; i_mod_ready = k[1]; i_len = 8'(k + 1);
            #1;
            outs = {o_data_ready, o_sym_I, o_sym_Q, o_sym_valid, o_busy, o_done, o_underrun};
            checks++;
            if (outs !== 7'b0) begin
                errors++;
                $display("FAIL reset_outs cycle %0d: got %b expected 0000000", k, outs);
            end
        end
        i_start = 1'b0; i_data_valid = 1'b0; i_mod_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b sym_valid=%b expected 0 0", o_busy, o_sym_valid);
        end
    endtask

    task automatic test_single_byte();
        logic [1:0] exp_s[14] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3,
                                  2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
        bit to;
        start_frame(8'd1, 1'b1, 8'hB4);
        wait_done(to);
        checks++;
        if (to || sym_q.size() != 14) begin
            errors++;
            $display("FAIL single_count: timeout=%0d symbols=%0d expected 0 14", to, sym_q.size());
        end
        for (int k = 0; k < 14 && k < sym_q.size(); k++) begin
            checks++;
            if (sym_q[k] !== exp_s[k] || (sym_t[k] - sym_t[0]) != 4 * k) begin
                errors++;
                $display("FAIL single_sym %0d: got %b at +%0d expected %b at +%0d",
                         k, sym_q[k], sym_t[k] - sym_t[0], exp_s[k], 4 * k);
            end
        end
        checks++;
        if (sym_q.size() == 0 || done_t - sym_t[0] != 56 || busy_at_done !== 1'b0 || und_cnt != 0) begin
            errors++;
            $display("FAIL single_done: at +%0d busy=%b underruns=%0d expected +56 0 0",
                     (sym_q.size() > 0) ? done_t - sym_t[0] : -1, busy_at_done, und_cnt);
        end
    endtask

    task automatic test_zero_len();
        bit to;
        start_frame(8'd0, 1'b0, 8'h00);
        wait_done(to);
        checks++;
        if (to || sym_q.size() != 10 || done_t - sym_t[0] != 40) begin
            errors++;
            $display("FAIL zero_len_frame: timeout=%0d symbols=%0d done=+%0d expected 0 10 +40",
                     to, sym_q.size(), (sym_q.size() > 0) ? done_t - sym_t[0] : -1);
        end
        checks++;
        if (sym_q.size() == 10 && (sym_q[7] !== 2'b11 || sym_q[8] !== 2'b00 || sym_q[9] !== 2'b00)) begin
            errors++;
            $display("FAIL zero_len_syms: got %b %b %b expected 11 00 00", sym_q[7], sym_q[8], sym_q[9]);
        end
        checks++;
        if (ready_seen !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_ready: data_ready seen=%b expected 0", ready_seen);
        end
    endtask

    task automatic test_underrun();
        logic [1:0] exp_s[14] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3,
                                  2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
        bit to;
        start_frame(8'd3, 1'b1, 8'hB4);
        wait_done(to);
        checks++;
        if (to || sym_q.size() != 14 || und_cnt != 1) begin
            errors++;
            $display("FAIL underrun_count: timeout=%0d symbols=%0d underruns=%0d expected 0 14 1",
                     to, sym_q.size(), und_cnt);
        end
        checks++;
        if (sym_q.size() == 0 || und_t - sym_t[0] != 48 || done_t - sym_t[0] != 56) begin
            errors++;
            $display("FAIL underrun_timing: underrun=+%0d done=+%0d expected +48 +56",
                     (sym_q.size() > 0) ? und_t - sym_t[0] : -1, (sym_q.size() > 0) ? done_t - sym_t[0] : -1);
        end
        for (int k = 8; k < 14 && k < sym_q.size(); k++) begin
            checks++;
            if (sym_q[k] !== exp_s[k]) begin
                errors++;
                $display("FAIL underrun_sym %0d: got %b expected %b", k, sym_q[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_stall();
        logic [1:0] exp_s[14] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3,
                                  2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
        logic [1:0] hold;
        bit to;
        start_frame(8'd1, 1'b1, 8'h1B);
        wait_syms(10, to);
        @(posedge clk); #1;
        hold = {o_sym_I, o_sym_Q};
        i_mod_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({o_sym_I, o_sym_Q} !== 2'b01 || o_sym_valid !== 1'b0 || hold !== 2'b01) begin
                errors++;
                $display("FAIL stall_hold %0d: got %b valid=%b expected 01 0",
                         k, {o_sym_I, o_sym_Q}, o_sym_valid);
            end
        end
        i_mod_ready = 1'b1;
        wait_done(to);
        checks++;
        if (to || sym_q.size() != 14 || done_t - sym_t[0] != 61) begin
            errors++;
            $display("FAIL stall_frame: timeout=%0d symbols=%0d done=+%0d expected 0 14 +61",
                     to, sym_q.size(), (sym_q.size() > 0) ? done_t - sym_t[0] : -1);
        end
        for (int k = 0; k < 14 && k < sym_q.size(); k++) begin
            checks++;
            if (sym_q[k] !== exp_s[k] || (sym_t[k] - sym_t[0]) != ((k < 10) ? 4 * k : 4 * k + 5)) begin
                errors++;
                $display("FAIL stall_sym %0d: got %b at +%0d expected %b at +%0d",
                         k, sym_q[k], sym_t[k] - sym_t[0], exp_s[k], (k < 10) ? 4 * k : 4 * k + 5);
            end
        end
    endtask

    task automatic test_start_and_reset();
        logic [6:0] outs;
        bit to;
        // A second start mid-payload must not disturb the frame
        start_frame(8'd1, 1'b1, 8'hB4);
        wait_syms(9, to);
        i_start = 1'b1; i_len = 8'd0;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done(to);
        checks++;
        if (to || sym_q.size() != 14 || done_t - sym_t[0] != 56 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start: timeout=%0d symbols=%0d done=+%0d dones=%0d expected 0 14 +56 1",
                     to, sym_q.size(), (sym_q.size() > 0) ? done_t - sym_t[0] : -1, done_cnt);
        end
        // Reset in the middle of the payload
        start_frame(8'd1, 1'b1, 8'hB4);
        wait_syms(10, to);
        rst_n = 1'b0;
        #1;
        outs = {o_data_ready, o_sym_I, o_sym_Q, o_sym_valid, o_busy, o_done, o_underrun};
        checks++;
        if (to || outs !== 7'b0) begin
            errors++;
            $display("FAIL midframe_reset: timeout=%0d outs=%b expected 0 0000000", to, outs);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (done_cnt != 0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: dones=%0d busy=%b expected 0 0", done_cnt, o_busy);
        end
        // Clean frame after the abort
        start_frame(8'd1, 1'b1, 8'h1B);
        wait_done(to);
        checks++;
        if (to || sym_q.size() != 14 || done_t - sym_t[0] != 56) begin
            errors++;
            $display("FAIL post_reset_frame: timeout=%0d symbols=%0d done=+%0d expected 0 14 +56",
                     to, sym_q.size(), (sym_q.size() > 0) ? done_t - sym_t[0] : -1);
        end
        checks++;
        if (sym_q.size() == 14 && {sym_q[8], sym_q[9], sym_q[10], sym_q[11]} !== 8'h1B) begin
            errors++;
            $display("FAIL post_reset_payload: got %h expected 1b",
                     {sym_q[8], sym_q[9], sym_q[10], sym_q[11]});
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_single_byte();
        test_zero_len();
        test_underrun();
        test_stall();
        test_start_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
